dcm_lock_supervisor: RTL and testbench



---
 rtl/dcm_lock_supervisor.sv | 200 ++++++++++++++++++++
 tb/tb_dcm_lock_supervisor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_lock_supervisor.sv
// DCM reset/lock supervisor running on the raw reference clock: pulses the DCM reset, retries on timeout or loss of lock, and releases the core reset after a stable-lock hold time.
// Defining DCM_FXSTOP_MON_EN adds monitoring of STATUS[2] (CLKFX stopped) in SETTLE and RUN.
module dcm_lock_supervisor #(
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int HOLD_CYCLES  = 16,
    parameter int MAX_RETRIES  = 7
) (
    input  logic       i_clkin,
    input  logic       i_reset,
    input  logic       i_locked,
    input  logic [7:0] i_status,
    output logic       o_dcm_rst,
    output logic       o_clk_good,
    output logic       o_core_reset,
    output logic       o_fail,
    output logic [3:0] o_retry_count
);

    typedef enum logic [2:0] {
        ST_RESET_DCM = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [3:0]  r_retry;
    logic [3:0]  w_retry_nxt;
    logic [1:0]  r_lock_sync;
    logic        w_locked_s;
    logic        w_fxstop_s;
    logic        w_lock_good;
    logic        w_unused_status;
    logic        r_dcm_rst;
    logic        r_clk_good;
    logic        r_core_reset;
    logic        r_fail;
    logic        w_dcm_rst_nxt;
    logic        w_clk_good_nxt;
    logic        w_core_reset_nxt;
    logic        w_fail_nxt;

    // Two-flop synchronizer for the asynchronous LOCKED input.
    always_ff @(posedge i_clkin or posedge i_reset) begin
        if (i_reset) begin
            r_lock_sync <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], i_locked};
        end
    end

    assign w_locked_s = r_lock_sync[1];

`ifdef DCM_FXSTOP_MON_EN
    logic [1:0] r_fxstop_sync;

    // Two-flop synchronizer for STATUS[2] (CLKFX stopped).
    always_ff @(posedge i_clkin or posedge i_reset) begin
        if (i_reset) begin
            r_fxstop_sync <= 2'b00;
        end else begin
            r_fxstop_sync <= {r_fxstop_sync[0], i_status[2]};
        end
    end

    assign w_fxstop_s = r_fxstop_sync[1];
`else
    assign w_fxstop_s = 1'b0;
`endif

    // Only STATUS[2] is of interest; the other bits are intentionally sunk.
    assign w_unused_status = ^i_status;
    assign w_lock_good     = w_locked_s & ~w_fxstop_s;

    // State, shared counter and retry counter registers.
    always_ff @(posedge i_clkin or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RESET_DCM;
            r_cnt   <= 16'd0;
            r_retry <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    // Next-state, counter and retry decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        case (r_state)
            ST_RESET_DCM: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 16'd1;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_cnt_nxt = 16'd0;
                    if (r_retry == RETRY_MAX) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_state_nxt = ST_RESET_DCM;
                        w_retry_nxt = r_retry + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_SETTLE: begin
                // A drop restarts the lock wait without consuming a retry.
                if (!w_lock_good) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 16'd0;
                    w_retry_nxt = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_RUN: begin
                if (!w_lock_good) begin
                    w_state_nxt = ST_RESET_DCM;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = 16'd0;
                end
            end
            ST_FAULT: begin
                w_cnt_nxt = 16'd0;
            end
            default: begin
                w_state_nxt = ST_RESET_DCM;
                w_cnt_nxt   = 16'd0;
                w_retry_nxt = 4'd0;
            end
        endcase
    end

    // Moore output decode from the next state, so outputs move with the state.
    always_comb begin
        w_dcm_rst_nxt    = 1'b0;
        w_clk_good_nxt   = 1'b0;
        w_core_reset_nxt = 1'b1;
        w_fail_nxt       = 1'b0;
        case (w_state_nxt)
            ST_RESET_DCM: w_dcm_rst_nxt = 1'b1;
            ST_WAIT_LOCK: w_dcm_rst_nxt = 1'b0;
            ST_SETTLE:    w_dcm_rst_nxt = 1'b0;
            ST_RUN: begin
                w_clk_good_nxt   = 1'b1;
                w_core_reset_nxt = 1'b0;
            end
            ST_FAULT:     w_fail_nxt = 1'b1;
            default:      w_dcm_rst_nxt = 1'b1;
        endcase
    end

    // Output registers.
    always_ff @(posedge i_clkin or posedge i_reset) begin
        if (i_reset) begin
            r_dcm_rst    <= 1'b1;
            r_clk_good   <= 1'b0;
            r_core_reset <= 1'b1;
            r_fail       <= 1'b0;
        end else begin
            r_dcm_rst    <= w_dcm_rst_nxt;
            r_clk_good   <= w_clk_good_nxt;
            r_core_reset <= w_core_reset_nxt;
            r_fail       <= w_fail_nxt;
        end
    end

    assign o_dcm_rst     = r_dcm_rst;
    assign o_clk_good    = r_clk_good;
    assign o_core_reset  = r_core_reset;
    assign o_fail        = r_fail;
    assign o_retry_count = r_retry;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Self-checking bench for dcm_lock_supervisor: directed scenarios with randomized timing, checked against a timeline model and the spec's latency formulas.
module tb_dcm_lock_supervisor;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 100;
    localparam int HOLD_CYCLES  = 16;
    localparam int MAX_RETRIES  = 2;
    localparam int ATTEMPT      = RST_CYCLES + LOCK_TIMEOUT;
`ifdef DCM_FXSTOP_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    localparam int M_RST    = 0;
    localparam int M_WAIT   = 1;
    localparam int M_SETTLE = 2;
    localparam int M_RUN    = 3;
    localparam int M_FAULT  = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       locked = 1'b0;
    logic [7:0] status = 8'd0;
    logic       dcm_rst;
    logic       clk_good;
    logic       core_reset;
    logic       fail;
    logic [3:0] retry_count;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    int m_mode;
    int m_age;
    int m_tries;
    bit m_lk1, m_lk2, m_fx1, m_fx2;

    int rises[$];
    int falls[$];
    int fail_edge;
    int d;
    int e_lock;
    int e_drop;
    bit prev;

    dcm_lock_supervisor #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .HOLD_CYCLES (HOLD_CYCLES),
        .MAX_RETRIES (MAX_RETRIES)
    ) u_dut (
        .i_clkin      (clk),
        .i_reset      (rst),
        .i_locked     (locked),
        .i_status     (status),
        .o_dcm_rst    (dcm_rst),
        .o_clk_good   (clk_good),
        .o_core_reset (core_reset),
        .o_fail       (fail),
        .o_retry_count(retry_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_RST;
        m_age   = 0;
        m_tries = 0;
        m_lk1 = 1'b0; m_lk2 = 1'b0; m_fx1 = 1'b0; m_fx2 = 1'b0;
    endtask

    task automatic enter(input int mode);
        m_mode = mode;
        m_age  = 0;
    endtask

    // One clock edge of the timeline model: the FSM sees inputs sampled two edges earlier.
    task automatic model_edge();
        bit seen_lock, seen_fx, healthy;
        seen_lock = m_lk2;
        seen_fx   = m_fx2;
        m_lk2 = m_lk1; m_lk1 = locked;
        m_fx2 = m_fx1; m_fx1 = status[2];
        healthy = seen_lock && !(MON && seen_fx);
        case (m_mode)
            M_RST: begin
                m_age++;
                if (m_age == RST_CYCLES) enter(M_WAIT);
            end
            M_WAIT: begin
                if (seen_lock) enter(M_SETTLE);
                else begin
                    m_age++;
                    if (m_age == LOCK_TIMEOUT) begin
                        if (m_tries == MAX_RETRIES) enter(M_FAULT);
                        else begin
                            m_tries++;
                            enter(M_RST);
                        end
                    end
                end
            end
            M_SETTLE: begin
                if (!healthy) enter(M_WAIT);
                else begin
                    m_age++;
                    if (m_age == HOLD_CYCLES) begin
                        m_tries = 0;
                        enter(M_RUN);
                    end
                end
            end
            M_RUN: if (!healthy) enter(M_RST);
            M_FAULT: m_age = 0;
            default: enter(M_RST);
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dcm_rst"},    {31'd0, dcm_rst},    {31'd0, (m_mode == M_RST)});
        check({tag, ".clk_good"},   {31'd0, clk_good},   {31'd0, (m_mode == M_RUN)});
        check({tag, ".core_reset"}, {31'd0, core_reset}, {31'd0, (m_mode != M_RUN)});
        check({tag, ".fail"},       {31'd0, fail},       {31'd0, (m_mode == M_FAULT)});
        check({tag, ".retry"},      {28'd0, retry_count}, 32'(m_tries));
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (rst) model_reset();
        else model_edge();
        #1;
        check_all("cycle");
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset: outputs must take reset values before any clock edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        run(2);
        rst    = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        // Power-on reset and the first DCM reset pulse.
        #1;
        do_reset("por");
        for (int i = 0; i < 20 && dcm_rst === 1'b1; i++) tick();
        check("dcm_rst_pulse_len", edge_n, RST_CYCLES);

        // Normal acquisition: lock about 50 cycles after release.
        d = $urandom_range(45, 55);
        run(d - edge_n);
        locked = 1'b1;
        e_lock = edge_n + 1;
        for (int i = 0; i < 60 && clk_good !== 1'b1; i++) tick();
        check("release_latency", edge_n - e_lock, HOLD_CYCLES + 2);
        check("release_core_reset", {31'd0, core_reset}, 32'd0);
        check("release_retry", {28'd0, retry_count}, 32'd0);
        run($urandom_range(5, 20));

        // Loss of lock in RUN.
        d = $urandom_range(3, 6);
        locked = 1'b0;
        e_drop = edge_n + 1;
        run(2);
        check("drop_still_good", {31'd0, clk_good}, 32'd1);
        tick();
        check("drop_dcm_rst", {31'd0, dcm_rst}, 32'd1);
        check("drop_clk_good", {31'd0, clk_good}, 32'd0);
        check("drop_core_reset", {31'd0, core_reset}, 32'd1);
        run(d - 3);
        locked = 1'b1;
        for (int i = 0; i < 20 && dcm_rst === 1'b1; i++) tick();
        check("drop_pulse_len", edge_n - (e_drop + 2), RST_CYCLES);
        for (int i = 0; i < 60 && clk_good !== 1'b1; i++) tick();
        check("relock_clk_good", {31'd0, clk_good}, 32'd1);
        run($urandom_range(5, 15));

        // CLKFX stopped for 4 cycles while locked stays high.
        status[2] = 1'b1;
        run(3);
        check("fxstop_clk_good", {31'd0, clk_good}, MON ? 32'd0 : 32'd1);
        check("fxstop_dcm_rst", {31'd0, dcm_rst}, MON ? 32'd1 : 32'd0);
        tick();
        status[2] = 1'b0;
        for (int i = 0; i < 60 && clk_good !== 1'b1; i++) tick();
        check("fxstop_recover", {31'd0, clk_good}, 32'd1);

        // Unstable lock in SETTLE: 10 high, 3 low, then high.
        locked = 1'b0;
        do_reset("rst_unstable");
        run($urandom_range(10, 30));
        locked = 1'b1;
        run(10);
        locked = 1'b0;
        run(3);
        check("unstable_no_release", {31'd0, clk_good}, 32'd0);
        locked = 1'b1;
        e_lock = edge_n + 1;
        for (int i = 0; i < 60 && clk_good !== 1'b1; i++) tick();
        check("unstable_latency", edge_n - e_lock, HOLD_CYCLES + 2);
        check("unstable_retry", {28'd0, retry_count}, 32'd0);

        // Reset while waiting for lock after one retry.
        locked = 1'b0;
        do_reset("rst_pre_wait");
        for (int i = 0; i < 200 && retry_count !== 4'd1; i++) tick();
        check("first_retry_edge", edge_n, ATTEMPT);
        run(30);
        check("wait_retry1", {28'd0, retry_count}, 32'd1);
        do_reset("rst_in_wait");

        // Lock timeout, retries and fault.
        fail_edge = -1;
        for (int i = 0; i < 330; i++) begin
            prev = dcm_rst;
            tick();
            if (!prev && dcm_rst) rises.push_back(edge_n);
            if (prev && !dcm_rst) falls.push_back(edge_n);
            if (fail === 1'b1 && fail_edge < 0) fail_edge = edge_n;
        end
        check("n_rises", rises.size(), MAX_RETRIES);
        for (int k = 0; k < rises.size() && k < MAX_RETRIES; k++)
            check("rise_edge", rises[k], ATTEMPT * (k + 1));
        check("n_falls", falls.size(), MAX_RETRIES + 1);
        for (int k = 0; k < falls.size() && k < MAX_RETRIES + 1; k++)
            check("fall_edge", falls[k], ATTEMPT * k + RST_CYCLES);
        check("fail_edge", fail_edge, (MAX_RETRIES + 1) * ATTEMPT);
        run(20);
        check("fault_dcm_rst", {31'd0, dcm_rst}, 32'd0);
        check("fault_sticky", {31'd0, fail}, 32'd1);

        // Reset out of FAULT and a clean restart.
        do_reset("rst_in_fault");
        check("fault_cleared", {31'd0, fail}, 32'd0);
        run($urandom_range(20, 40) - edge_n);
        locked = 1'b1;
        e_lock = edge_n + 1;
        for (int i = 0; i < 60 && clk_good !== 1'b1; i++) tick();
        check("restart_latency", edge_n - e_lock, HOLD_CYCLES + 2);
        run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
